// File: rtl/meas_pkg.sv
// Shared types and constants for the measurement sequencer: state encoding,
// CLEAR length, overflow bit positions and a cycle-parameter range check.
package meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_GATE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LATCH  = 3'd4,
        ST_HOLD   = 3'd5
    } meas_state_e;

    localparam int unsigned CLEAR_CYCLES = 2;

    localparam int unsigned OVF_CNT1 = 0;
    localparam int unsigned OVF_CNT2 = 1;

    // A cycle count is usable if it is at least 1 and (count-1) loads into the timer.
    function automatic bit cycles_ok(longint unsigned cycles, int unsigned width);
        return (cycles >= 64'd1) && ((width >= 64) || (cycles <= (64'd1 << width)));
    endfunction

endpackage

// File: rtl/meas_win_timer.sv
// Loadable down-counter; done_o is high while the count has reached zero.
module meas_win_timer #(
    parameter int unsigned TMR_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             done_o
);

    logic [TMR_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/meas_seq_ctrl.sv
// Measurement sequencer: clear, gate, settle, latch and hold the dual counters.
// Optional MEAS_DIFF_EN adds the registered signed difference output res_diff_o.
module meas_seq_ctrl
    import meas_pkg::*;
#(
    parameter int unsigned CNT_W         = 34,
    parameter int unsigned TMR_W         = 32,
    parameter int unsigned GATE_CYCLES   = 100_000_000,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES   = 50_000_000
) (
    input  logic             clk_100MHz_i,
    input  logic             rst_n,
    input  logic             lock_i,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] cnt_val_1_i,
    input  logic [CNT_W-1:0] cnt_val_2_i,
    output logic             cnt_clr_o,
    output logic             cnt_en_o,
    output logic             busy_o,
    output logic             res_valid_o,
    output logic [CNT_W-1:0] res_1_o,
    output logic [CNT_W-1:0] res_2_o,
    output logic [1:0]       ovf_o,
    output logic [2:0]       state_o
`ifdef MEAS_DIFF_EN
    ,
    output logic signed [CNT_W:0] res_diff_o
`endif
);

    if (!(cycles_ok(64'(GATE_CYCLES), TMR_W) && cycles_ok(64'(SETTLE_CYCLES), TMR_W) &&
          cycles_ok(64'(HOLD_CYCLES), TMR_W) && cycles_ok(64'(CLEAR_CYCLES), TMR_W))) begin : g_param_err
        $error("meas_seq_ctrl: cycle parameter < 1 or too large for TMR_W");
    end

    localparam logic [TMR_W-1:0] CLEAR_LD  = TMR_W'(CLEAR_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(HOLD_CYCLES - 1);

    meas_state_e      state_q, state_d;
    logic             tmr_load, tmr_done;
    logic [TMR_W-1:0] tmr_val;

    logic             cnt_clr_q, cnt_clr_d;
    logic             cnt_en_q, cnt_en_d;
    logic             busy_q, busy_d;
    logic             res_valid_q, res_valid_d;
    logic [CNT_W-1:0] res_1_q, res_1_d;
    logic [CNT_W-1:0] res_2_q, res_2_d;
    logic [1:0]       ovf_q, ovf_d;

    meas_win_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clk_i      (clk_100MHz_i),
        .rst_ni     (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clk_100MHz_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The timer is loaded on every state change so it is primed on the first cycle of the new state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (!abort_i && lock_i && (start_i || cont_i)) state_d = ST_CLEAR;
            ST_CLEAR:  if (abort_i || !lock_i) state_d = ST_IDLE;
                       else if (tmr_done)      state_d = ST_GATE;
            ST_GATE:   if (abort_i || !lock_i) state_d = ST_IDLE;
                       else if (tmr_done)      state_d = ST_SETTLE;
            ST_SETTLE: if (abort_i || !lock_i) state_d = ST_IDLE;
                       else if (tmr_done)      state_d = ST_LATCH;
            ST_LATCH:  state_d = ST_HOLD;
            ST_HOLD:   if (abort_i)            state_d = ST_IDLE;
                       else if (tmr_done)      state_d = (cont_i && lock_i) ? ST_CLEAR : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        tmr_load = (state_d != state_q);
        unique case (state_d)
            ST_CLEAR:  tmr_val = CLEAR_LD;
            ST_GATE:   tmr_val = GATE_LD;
            ST_SETTLE: tmr_val = SETTLE_LD;
            ST_HOLD:   tmr_val = HOLD_LD;
            default:   tmr_val = '0;
        endcase
    end

    // Outputs are decoded from the next state so the registered value lines up with the state.
    always_comb begin
        cnt_clr_d   = (state_d == ST_CLEAR);
        cnt_en_d    = (state_d == ST_GATE);
        busy_d      = (state_d != ST_IDLE);
        res_valid_d = res_valid_q;
        res_1_d     = res_1_q;
        res_2_d     = res_2_q;
        ovf_d       = ovf_q;
        if (state_q == ST_LATCH) begin
            res_1_d          = cnt_val_1_i;
            res_2_d          = cnt_val_2_i;
            ovf_d[OVF_CNT1]  = &cnt_val_1_i;
            ovf_d[OVF_CNT2]  = &cnt_val_2_i;
            res_valid_d      = 1'b1;
        end
        if (state_d == ST_CLEAR) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_100MHz_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_clr_q   <= 1'b0;
            cnt_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_1_q     <= '0;
            res_2_q     <= '0;
            ovf_q       <= '0;
        end else begin
            cnt_clr_q   <= cnt_clr_d;
            cnt_en_q    <= cnt_en_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_1_q     <= res_1_d;
            res_2_q     <= res_2_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef MEAS_DIFF_EN
    logic signed [CNT_W:0] res_diff_q, res_diff_d;

    always_comb begin
        res_diff_d = res_diff_q;
        if (state_q == ST_LATCH) begin
            res_diff_d = $signed({1'b0, cnt_val_1_i}) - $signed({1'b0, cnt_val_2_i});
        end
    end

    always_ff @(posedge clk_100MHz_i or negedge rst_n) begin
        if (!rst_n) begin
            res_diff_q <= '0;
        end else begin
            res_diff_q <= res_diff_d;
        end
    end

    assign res_diff_o = res_diff_q;
`else
    // Without the difference option no subtractor or extra register is built.
`endif

    assign cnt_clr_o   = cnt_clr_q;
    assign cnt_en_o    = cnt_en_q;
    assign busy_o      = busy_q;
    assign res_valid_o = res_valid_q;
    assign res_1_o     = res_1_q;
    assign res_2_o     = res_2_q;
    assign ovf_o       = ovf_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_meas_seq_ctrl.sv
// Self-checking bench for meas_seq_ctrl with G=10, S=2, H=5, CNT_W=8.
// Define MEAS_DIFF_EN for both RTL and bench to exercise res_diff_o.
module tb_meas_seq_ctrl;

    localparam int G  = 10;
    localparam int S  = 2;
    localparam int H  = 5;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lock = 1'b1, start = 1'b0, cont = 1'b0, abort = 1'b0;
    logic [CW-1:0] cnt_val_1, cnt_val_2;
    logic          cnt_clr, cnt_en, busy, res_valid;
    logic [CW-1:0] res_1, res_2;
    logic [1:0]    ovf;
    logic [2:0]    state;
`ifdef MEAS_DIFF_EN
    logic signed [CW:0] res_diff;
`endif

    always #5 clk = ~clk;

    meas_seq_ctrl #(
        .CNT_W         (CW),
        .TMR_W         (16),
        .GATE_CYCLES   (G),
        .SETTLE_CYCLES (S),
        .HOLD_CYCLES   (H)
    ) dut (
        .clk_100MHz_i (clk),
        .rst_n        (rst_n),
        .lock_i       (lock),
        .start_i      (start),
        .cont_i       (cont),
        .abort_i      (abort),
        .cnt_val_1_i  (cnt_val_1),
        .cnt_val_2_i  (cnt_val_2),
        .cnt_clr_o    (cnt_clr),
        .cnt_en_o     (cnt_en),
        .busy_o       (busy),
        .res_valid_o  (res_valid),
        .res_1_o      (res_1),
        .res_2_o      (res_2),
        .ovf_o        (ovf),
        .state_o      (state)
`ifdef MEAS_DIFF_EN
        ,
        .res_diff_o   (res_diff)
`endif
    );

    // Counter model: counter 1 steps by 1, counter 2 by step2, both while enabled.
    logic [CW-1:0] c1 = '0, c2 = '0, step2 = 8'd3;
    logic          ovr = 1'b0;
    logic [CW-1:0] ovr1 = '0, ovr2 = '0;
    assign cnt_val_1 = ovr ? ovr1 : c1;
    assign cnt_val_2 = ovr ? ovr2 : c2;

    always @(posedge clk) begin
        if (cnt_clr) begin
            c1 <= '0;
            c2 <= '0;
        end else if (cnt_en) begin
            c1 <= c1 + 8'd1;
            c2 <= c2 + step2;
        end
    end

    typedef struct {
        logic [CW-1:0] r1;
        logic [CW-1:0] r2;
        logic [1:0]    ovf;
        int            diff;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic prev_valid = 1'b0;

    task automatic push_exp(input logic [CW-1:0] v1, input logic [CW-1:0] v2);
        exp_t e;
        e.r1   = v1;
        e.r2   = v2;
        e.ovf  = {v2 == 8'hFF, v1 == 8'hFF};
        e.diff = int'(v1) - int'(v2);
        sb.push_back(e);
    endtask

    // Scoreboard: each rising edge of res_valid consumes one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (res_valid === 1'b1 && prev_valid !== 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_result: got res_1=%0d res_2=%0d, expected no result", res_1, res_2);
            end else begin
                e = sb.pop_front();
                if (res_1 !== e.r1) begin n_fail++; $display("FAIL sb_res_1: got %0d expected %0d", res_1, e.r1); end
                n_tests++;
                if (res_2 !== e.r2) begin n_fail++; $display("FAIL sb_res_2: got %0d expected %0d", res_2, e.r2); end
                n_tests++;
                if (ovf !== e.ovf) begin n_fail++; $display("FAIL sb_ovf: got %b expected %b", ovf, e.ovf); end
`ifdef MEAS_DIFF_EN
                n_tests++;
                if ($signed(res_diff) != e.diff) begin n_fail++; $display("FAIL sb_diff: got %0d expected %0d", $signed(res_diff), e.diff); end
`endif
            end
        end
        prev_valid = res_valid;
    end

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) step();
    endtask

    task automatic start_meas();
        cyc   = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({cnt_clr, cnt_en, busy, res_valid, res_1, res_2, ovf} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected all zero", {cnt_clr, cnt_en, busy, res_valid, res_1, res_2, ovf});
        end
        n_tests++;
        if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if (state !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle: state=%0d busy=%b expected 0/0", state, busy); end
        end
    endtask

    task automatic test_single_shot();
        logic [2:0] exp_st;
        step2 = 8'd3;
        push_exp(8'd10, 8'd30);
        start_meas();
        for (int k = 1; k <= 21; k++) begin
            exp_st = (k <= 2) ? 3'd1 : (k <= 12) ? 3'd2 : (k <= 14) ? 3'd3 : (k == 15) ? 3'd4 : (k <= 20) ? 3'd5 : 3'd0;
            n_tests++;
            if (cnt_clr !== (k <= 2)) begin n_fail++; $display("FAIL single_clr c%0d: got %b expected %b", k, cnt_clr, k <= 2); end
            n_tests++;
            if (cnt_en !== (k >= 3 && k <= 12)) begin n_fail++; $display("FAIL single_en c%0d: got %b expected %b", k, cnt_en, k >= 3 && k <= 12); end
            n_tests++;
            if (res_valid !== (k >= 16)) begin n_fail++; $display("FAIL single_valid c%0d: got %b expected %b", k, res_valid, k >= 16); end
            n_tests++;
            if (busy !== (k <= 20)) begin n_fail++; $display("FAIL single_busy c%0d: got %b expected %b", k, busy, k <= 20); end
            n_tests++;
            if (state !== exp_st) begin n_fail++; $display("FAIL single_state c%0d: got %0d expected %0d", k, state, exp_st); end
            step();
        end
    endtask

    task automatic test_abort();
        start_meas();
        run_to(7);
        n_tests++;
        if (cnt_en !== 1'b1) begin n_fail++; $display("FAIL abort_pre_en: got %b expected 1", cnt_en); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_tests++;
        if ({cnt_en, cnt_clr, busy, state} !== 6'd0) begin n_fail++; $display("FAIL abort_gate_outputs: en=%b clr=%b busy=%b state=%0d expected all 0", cnt_en, cnt_clr, busy, state); end
        n_tests++;
        if (res_valid !== 1'b0 || res_1 !== 8'd10 || res_2 !== 8'd30) begin
            n_fail++; $display("FAIL abort_gate_results: valid=%b r1=%0d r2=%0d expected 0/10/30", res_valid, res_1, res_2);
        end
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (state !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_start_same_cycle: state=%0d busy=%b expected 0/0", state, busy); end
            step();
        end
        push_exp(8'd10, 8'd30);
        start_meas();
        run_to(5);
        start = 1'b1;
        step();
        start = 1'b0;
        run_to(16);
        n_tests++;
        if (res_valid !== 1'b1) begin n_fail++; $display("FAIL busy_start_ignored_valid: got %b expected 1 at cycle 16", res_valid); end
        run_to(18);
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_tests++;
        if (state !== 3'd0 || res_valid !== 1'b1 || res_1 !== 8'd10) begin
            n_fail++; $display("FAIL abort_hold: state=%0d valid=%b r1=%0d expected 0/1/10", state, res_valid, res_1);
        end
        run_to(26);
        n_tests++;
        if (state !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_not_queued: state=%0d busy=%b expected 0/0", state, busy); end
    endtask

    task automatic test_lock();
        lock  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (state !== 3'd0) begin n_fail++; $display("FAIL lock_low_start: state=%0d expected 0", state); end
            step();
        end
        lock = 1'b1;
        start_meas();
        run_to(13);
        n_tests++;
        if (state !== 3'd3) begin n_fail++; $display("FAIL lock_settle_reached: state=%0d expected 3", state); end
        lock = 1'b0;
        step();
        n_tests++;
        if (state !== 3'd0 || busy !== 1'b0 || cnt_en !== 1'b0) begin
            n_fail++; $display("FAIL lock_drop_settle: state=%0d busy=%b en=%b expected 0/0/0", state, busy, cnt_en);
        end
        lock = 1'b1;
        run_to(30);
        n_tests++;
        if (res_valid !== 1'b0 || res_1 !== 8'd10 || state !== 3'd0) begin
            n_fail++; $display("FAIL lock_no_latch: valid=%b r1=%0d state=%0d expected 0/10/0", res_valid, res_1, state);
        end
    endtask

    task automatic test_continuous();
        logic exp_clr;
        step2 = 8'd2;
        push_exp(8'd10, 8'd20);
        push_exp(8'd10, 8'd50);
        push_exp(8'd10, 8'd70);
        cyc  = 0;
        cont = 1'b1;
        step();
        for (int k = 1; k <= 62; k++) begin
            if (k == 21) step2 = 8'd5;
            if (k == 41) step2 = 8'd7;
            if (k == 45) cont = 1'b0;
            exp_clr = (k <= 42) && (((k - 1) % 20) < 2);
            n_tests++;
            if (cnt_clr !== exp_clr) begin n_fail++; $display("FAIL cont_clr c%0d: got %b expected %b", k, cnt_clr, exp_clr); end
            n_tests++;
            if (busy !== (k <= 60)) begin n_fail++; $display("FAIL cont_busy c%0d: got %b expected %b", k, busy, k <= 60); end
            if (k == 20 || k == 40) begin
                n_tests++;
                if (res_valid !== 1'b1) begin n_fail++; $display("FAIL cont_valid_hold c%0d: got %b expected 1", k, res_valid); end
            end
            if (k == 21 || k == 41) begin
                n_tests++;
                if (res_valid !== 1'b0) begin n_fail++; $display("FAIL cont_valid_drop c%0d: got %b expected 0", k, res_valid); end
            end
            step();
        end
        n_tests++;
        if (state !== 3'd0) begin n_fail++; $display("FAIL cont_stop_idle: state=%0d expected 0", state); end
    endtask

    task automatic test_overflow_diff();
        logic [CW-1:0] va [4];
        logic [CW-1:0] vb [4];
        logic [1:0]    exp_ovf;
        va = '{8'hFF, 8'h28, 8'd100, 8'd40};
        vb = '{8'h28, 8'hFF, 8'd40, 8'd100};
        ovr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ovr1 = va[i];
            ovr2 = vb[i];
            exp_ovf = {vb[i] == 8'hFF, va[i] == 8'hFF};
            push_exp(va[i], vb[i]);
            start_meas();
            run_to(17);
            n_tests++;
            if (ovf !== exp_ovf) begin n_fail++; $display("FAIL ovf_flag pair%0d: got %b expected %b", i, ovf, exp_ovf); end
            run_to(22);
        end
        ovr = 1'b0;
    endtask

    task automatic test_reset_mid_gate();
        start_meas();
        run_to(6);
        n_tests++;
        if (cnt_en !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_en: got %b expected 1", cnt_en); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({cnt_clr, cnt_en, busy, res_valid, res_1, res_2, ovf} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %b expected all zero", {cnt_clr, cnt_en, busy, res_valid, res_1, res_2, ovf});
        end
        n_tests++;
        if (state !== 3'd0) begin n_fail++; $display("FAIL rst_mid_state: got %0d expected 0", state); end
`ifdef MEAS_DIFF_EN
        n_tests++;
        if (res_diff !== '0) begin n_fail++; $display("FAIL rst_mid_diff: got %0d expected 0", res_diff); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_tests++;
            if (state !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_release: state=%0d busy=%b expected 0/0", state, busy); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_shot();
        test_abort();
        test_lock();
        test_continuous();
        test_overflow_diff();
        test_reset_mid_gate();
        n_tests++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending results expected 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
